stream_packer: RTL and testbench
================================

// Module: stream_packer
//
// PURPOSE
//   Width-up converter on the destination side of cdc_fifo_2phase.
//   Accepts a narrow valid/ready stream of DATA_WIDTH beats and packs PACK_RATIO beats into one wide word.
//   in_last_i closes a packet early; that word is emitted with a lane strobe and out_last_o.
//   The output is registered, and the block sustains one input beat per cycle.
//
// PARAMETERS
//   DATA_WIDTH  32  width of one input beat (bits)
//   PACK_RATIO  4   input beats per output word; >=1 (1 = registered pass-through)
//
// PORTS
//   clk_i        in   1                      clock; all logic on rising edge
//   rst_ni       in   1                      reset: synchronous, active-low
//   in_data_i    in   DATA_WIDTH             input beat
//   in_last_i    in   1                      beat is last of packet; closes current word
//   in_valid_i   in   1                      input beat valid
//   in_ready_o   out  1                      input beat accepted when valid&&ready
//   out_data_o   out  DATA_WIDTH*PACK_RATIO  packed word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//   out_strb_o   out  PACK_RATIO             lane k holds valid data
//   out_last_o   out  1                      word ends a packet
//   out_valid_o  out  1                      output word valid
//   out_ready_i  in   1                      downstream accepts word
//
// BEHAVIOUR
//   - Reset (rst_ni=0 at clk edge) clears:
//     - lane counter to 0, accumulator and its strobe to 0
//     - out_valid_o=0, out_data_o='0, out_strb_o='0, out_last_o=0
//     - mid-word reset discards any partial word; no output is produced for it.
//   - in_ready_o = !out_valid_o || out_ready_i. It is combinational on registered state plus out_ready_i and never depends on in_valid_i.
//   - Accepted beat, lane index cnt:
//     - it is written to lane cnt; strobe bit cnt is set.
//     - completing beat: cnt==PACK_RATIO-1 or in_last_i=1.
//     - non-completing beat: cnt increments.
//     - completing beat: accumulator lanes plus the current beat load the output register in the same cycle.
//       - strobe = accumulated | (1<<cnt); out_last_o = in_last_i.
//       - cnt, accumulator and strobe clear to 0.
//   - Latency: completing beat accepted in cycle N -> out_valid_o=1 in cycle N+1. First beat of a word has latency PACK_RATIO cycles at full rate.
//   - Unfilled lanes of a short word read as 0.
//   - Output handshake (AXI-stream rules):
//     - out_valid_o holds until out_ready_i=1.
//     - out_data/strb/last stay stable while out_valid_o && !out_ready_i.
//     - simultaneous drain and refill in the same cycle -> new word loaded, out_valid_o stays 1, no bubble.
//   - Full-rate stream with out_ready_i=1 -> in_ready_o never deasserts.
//   - Backpressure stalls all input, including non-completing beats. This is deliberately simple and costs no throughput when downstream is ready.
//   - Counter width: $clog2(PACK_RATIO), min 1 bit; wraps only via the completion clear, never via overflow.
//   - in_last_i on lane PACK_RATIO-1 -> full strobe, out_last_o=1.
//   - PACK_RATIO=1 -> every beat completes; out_strb_o=1'b1.
//   - No internal state changes while in_valid_i && !in_ready_o.
//
// STRUCTURE
//   - Shared package stream_pkg:
//     - function lane_cnt_width(ratio) for the counter width
//     - no other typedefs; widths come from the parameters.
//   - One sub-module: stream_reg, a generic one-entry valid/ready output register. Parameterised on payload width = DATA_WIDTH*PACK_RATIO+PACK_RATIO+1.
//   - Accumulator, strobe and counter live in stream_packer itself.
//
// TESTING (DATA_WIDTH=8, PACK_RATIO=4 unless stated)
//   1. Beats 11,22,33,44 with last=0 and out_ready=1 -> next cycle out_data=0x44332211, strb=4'b1111, last=0.
//   2. Single beat AA with last=1 -> out_data=0x000000AA, strb=4'b0001, last=1; the following word starts in lane 0.
//   3. Word 1 complete, out_ready=0 for 5 cycles -> in_ready=0 for those cycles, out_data stable. Then ready=1 -> word handed over, in_ready=1 same cycle.
//   4. 1000 back-to-back beats (values 0..999 mod 256), out_ready=1 -> 250 words, in_ready never 0, lanes in order.
//   5. Two beats 01,02 accepted, then rst_ni=0 for 1 cycle, then 05,06,07,08 -> only output is 0x08070605 strb=4'b1111; no stale lanes.
//   6. PACK_RATIO=1: random valid/ready over 500 beats -> output equals input sequence, strb=1, last mirrors in_last.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared helpers for the stream width converters.
package stream_pkg;

  // Lane counter width; a single-lane packer still carries a 1-bit counter.
  function automatic int lane_cnt_width(input int ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/stream_reg.sv
// One-entry valid/ready register: holds a payload until the consumer takes it,
// and can be drained and refilled in the same cycle.
module stream_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (in_valid_i && in_ready_o) begin
      data_d  = in_data_i;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/stream_packer.sv
// Width-up converter: packs PACK_RATIO narrow beats into one registered wide
// word with a lane strobe; in_last_i closes a word early.
module stream_packer
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PACK_RATIO = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [DATA_WIDTH-1:0]            in_data_i,
  input  logic                             in_last_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data_o,
  output logic [PACK_RATIO-1:0]            out_strb_o,
  output logic                             out_last_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i
);

  localparam int CW = lane_cnt_width(PACK_RATIO);
  localparam int WW = DATA_WIDTH * PACK_RATIO;
  localparam int PW = WW + PACK_RATIO + 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WW-1:0]         acc_q, acc_d, word;
  logic [PACK_RATIO-1:0] strb_q, strb_d, strb_word;
  logic                  accept, complete;
  logic [PW-1:0]         out_payload;

  assign accept   = in_valid_i && in_ready_o;
  assign complete = in_last_i || (cnt_q == CW'(PACK_RATIO - 1));

  // Accumulator with the current beat merged into its lane.
  for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
    logic hit;
    assign hit = (cnt_q == CW'(gi));
    assign word[gi*DATA_WIDTH +: DATA_WIDTH] =
      hit ? in_data_i : acc_q[gi*DATA_WIDTH +: DATA_WIDTH];
    assign strb_word[gi] = strb_q[gi] | hit;
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    strb_d = strb_q;
    if (accept) begin
      if (complete) begin
        cnt_d  = '0;
        acc_d  = '0;
        strb_d = '0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        acc_d  = word;
        strb_d = strb_word;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      strb_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      strb_q <= strb_d;
    end
  end

  // Its ready also gates non-completing beats, so backpressure stalls everything.
  stream_reg #(
    .WIDTH(PW)
  ) u_out_reg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_data_i  ({in_last_i, strb_word, word}),
    .in_valid_i (in_valid_i && complete),
    .in_ready_o (in_ready_o),
    .out_data_o (out_payload),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  assign {out_last_o, out_strb_o, out_data_o} = out_payload;

endmodule

// File: tb/tb_stream_packer.sv
// Bench for stream_packer: a 4-lane and a 1-lane instance checked against a
// queue-based packing model.
module tb_stream_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_req;

  logic [7:0]  a_in_data;
  logic        a_in_last, a_in_valid, a_in_ready;
  logic [31:0] a_out_data;
  logic [3:0]  a_out_strb;
  logic        a_out_last, a_out_valid, a_out_ready;

  logic [7:0]  b_in_data;
  logic        b_in_last, b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic [0:0]  b_out_strb;
  logic        b_out_last, b_out_valid, b_out_ready;

  stream_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_data_i(a_in_data), .in_last_i(a_in_last), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .out_data_o(a_out_data), .out_strb_o(a_out_strb), .out_last_o(a_out_last),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready)
  );

  stream_packer #(.DATA_WIDTH(8), .PACK_RATIO(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_data_i(b_in_data), .in_last_i(b_in_last), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .out_data_o(b_out_data), .out_strb_o(b_out_strb), .out_last_o(b_out_last),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready)
  );

  typedef struct {logic [31:0] d; logic [3:0] s; logic l;} word_t;
  typedef struct {logic [7:0] d; logic l;} beat_t;

  word_t      exp_q[$], got_q[$];
  logic [7:0] cur_q[$];
  beat_t      exp1_q[$];
  beat_t      got1_q[$];
  logic       got1_strb_ok;
  int n_cmp = 0;
  int n_bad = 0;

  // One cycle on the 4-lane instance: drive at negedge, then note which
  // handshakes the coming posedge will perform and feed the packing model.
  task automatic step4(input logic v, input logic [7:0] d, input logic l, input logic ordy);
    word_t w;
    @(negedge clk);
    rst_n = rst_req;
    a_in_valid = v; a_in_data = d; a_in_last = l; a_out_ready = ordy;
    #1;
    if (!rst_n) begin
      cur_q.delete();
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    end else begin
      if (a_out_valid && ordy) begin
        w.d = a_out_data; w.s = a_out_strb; w.l = a_out_last;
        got_q.push_back(w);
      end
      if (v && a_in_ready) begin
        cur_q.push_back(d);
        if (l || cur_q.size() == 4) begin
          w.d = '0;
          foreach (cur_q[k]) w.d[8*k +: 8] = cur_q[k];
          w.s = 4'((1 << cur_q.size()) - 1);
          w.l = l;
          exp_q.push_back(w);
          cur_q.delete();
        end
      end
    end
  endtask

  task automatic step1(input logic v, input logic [7:0] d, input logic l, input logic ordy);
    beat_t b;
    @(negedge clk);
    rst_n = rst_req;
    b_in_valid = v; b_in_data = d; b_in_last = l; b_out_ready = ordy;
    #1;
    if (b_out_valid && ordy) begin
      b.d = b_out_data; b.l = b_out_last;
      got1_q.push_back(b);
      if (b_out_strb !== 1'b1) got1_strb_ok = 1'b0;
    end
    if (v && b_in_ready) begin
      b.d = d; b.l = l;
      exp1_q.push_back(b);
    end
  endtask

  task automatic pulse_reset();
    rst_req = 1'b0;
    step4(0, 8'h00, 0, 1);
    rst_req = 1'b1;
    got_q.delete(); exp_q.delete(); cur_q.delete();
  endtask

  task automatic test_reset();
    rst_req = 1'b0;
    step4(0, 8'h00, 0, 0);
    step4(0, 8'h00, 0, 0);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", a_out_data); end
    n_cmp++; if (a_out_strb !== 4'h0) begin n_bad++; $display("FAIL reset_strb: got %b want 0", a_out_strb); end
    n_cmp++; if (a_out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", a_out_last); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid_r1: got %b want 0", b_out_valid); end
    rst_req = 1'b1;
  endtask

  task automatic test_full_word();
    pulse_reset();
    step4(1, 8'h11, 0, 1); step4(1, 8'h22, 0, 1);
    step4(1, 8'h33, 0, 1); step4(1, 8'h44, 0, 1);
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL full_early: got %0d words want 0", got_q.size()); end
    step4(0, 8'h00, 0, 1);
    n_cmp++;
    if (got_q.size() != 1) begin n_bad++; $display("FAIL full_count: got %0d words want 1", got_q.size()); end
    else if (got_q[0].d !== 32'h44332211 || got_q[0].s !== 4'hf || got_q[0].l !== 1'b0) begin
      n_bad++; $display("FAIL full_word: got %h/%b/%b want 44332211/1111/0", got_q[0].d, got_q[0].s, got_q[0].l);
    end
  endtask

  task automatic test_short_word();
    pulse_reset();
    step4(1, 8'hAA, 1, 1);
    step4(1, 8'h55, 0, 1);
    step4(1, 8'h66, 1, 1);
    step4(0, 8'h00, 0, 1); step4(0, 8'h00, 0, 1);
    n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL short_count: got %0d words want 2", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_cmp++;
      if (got_q[0].d !== 32'h000000AA || got_q[0].s !== 4'b0001 || got_q[0].l !== 1'b1) begin
        n_bad++; $display("FAIL short_word: got %h/%b/%b want 000000aa/0001/1", got_q[0].d, got_q[0].s, got_q[0].l);
      end
    end
    if (got_q.size() >= 2) begin
      n_cmp++;
      if (got_q[1].d !== 32'h00006655 || got_q[1].s !== 4'b0011 || got_q[1].l !== 1'b1) begin
        n_bad++; $display("FAIL short_next_lane0: got %h/%b/%b want 00006655/0011/1", got_q[1].d, got_q[1].s, got_q[1].l);
      end
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    for (int i = 1; i <= 4; i++) step4(1, 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      step4(1, 8'h10, 0, 0);
      n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, a_in_ready); end
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out_data !== 32'h04030201) begin
        n_bad++; $display("FAIL bp_hold c%0d: got v=%b %h want v=1 04030201", i, a_out_valid, a_out_data);
      end
    end
    step4(1, 8'h10, 0, 1);
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", a_in_ready); end
    step4(1, 8'h11, 0, 1); step4(1, 8'h12, 0, 1); step4(1, 8'h13, 0, 1);
    repeat (3) step4(0, 8'h00, 0, 1);
    n_cmp++; if (got_q.size() != exp_q.size() || got_q.size() != 2) begin
      n_bad++; $display("FAIL bp_count: got %0d words want %0d (2)", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got_q[k].d !== exp_q[k].d || got_q[k].s !== exp_q[k].s || got_q[k].l !== exp_q[k].l) begin
        n_bad++; $display("FAIL bp_word%0d: got %h/%b/%b want %h/%b/%b", k, got_q[k].d, got_q[k].s, got_q[k].l, exp_q[k].d, exp_q[k].s, exp_q[k].l);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic stalled = 1'b0;
    pulse_reset();
    for (int i = 0; i < 1000; i++) begin
      step4(1, 8'(i % 256), 0, 1);
      if (a_in_ready !== 1'b1) stalled = 1'b1;
    end
    repeat (3) step4(0, 8'h00, 0, 1);
    n_cmp++; if (stalled) begin n_bad++; $display("FAIL b2b_in_ready: got a low cycle want never low"); end
    n_cmp++; if (got_q.size() != 250 || exp_q.size() != 250) begin
      n_bad++; $display("FAIL b2b_count: got %0d words want 250 (model %0d)", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got_q[k].d !== exp_q[k].d || got_q[k].s !== exp_q[k].s || got_q[k].l !== exp_q[k].l) begin
        n_bad++; $display("FAIL b2b_word%0d: got %h/%b/%b want %h/%b/%b", k, got_q[k].d, got_q[k].s, got_q[k].l, exp_q[k].d, exp_q[k].s, exp_q[k].l);
      end
    end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    step4(1, 8'h01, 0, 1); step4(1, 8'h02, 0, 1);
    rst_req = 1'b0;
    step4(0, 8'h00, 0, 1);
    rst_req = 1'b1;
    for (int i = 5; i <= 8; i++) step4(1, 8'(i), 0, 1);
    repeat (3) step4(0, 8'h00, 0, 1);
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL rst_count: got %0d words want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_cmp++;
      if (got_q[0].d !== 32'h08070605 || got_q[0].s !== 4'hf || got_q[0].l !== 1'b0) begin
        n_bad++; $display("FAIL rst_word: got %h/%b/%b want 08070605/1111/0", got_q[0].d, got_q[0].s, got_q[0].l);
      end
    end
  endtask

  task automatic test_random();
    logic v, l, ordy, hold, closed;
    logic [31:0] held_d;
    logic [3:0]  held_s;
    logic        held_l;
    int guard;
    hold = 1'b0;
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      step4(v, 8'($urandom), l, ordy);
      if (hold) begin
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_data !== held_d || a_out_strb !== held_s || a_out_last !== held_l) begin
          n_bad++; $display("FAIL rnd_stable c%0d: got v=%b %h/%b/%b want v=1 %h/%b/%b", i, a_out_valid, a_out_data, a_out_strb, a_out_last, held_d, held_s, held_l);
        end
      end
      hold = a_out_valid && !ordy;
      held_d = a_out_data; held_s = a_out_strb; held_l = a_out_last;
    end
    closed = 1'b0; guard = 0;
    while (!closed && guard < 20) begin
      step4(1, 8'hEE, 1, 1);
      closed = a_in_ready;
      guard++;
    end
    n_cmp++; if (!closed) begin n_bad++; $display("FAIL rnd_close: got no accept want accept within 20 cycles"); end
    repeat (3) step4(0, 8'h00, 0, 1);
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rnd_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got_q[k].d !== exp_q[k].d || got_q[k].s !== exp_q[k].s || got_q[k].l !== exp_q[k].l) begin
        n_bad++; $display("FAIL rnd_word%0d: got %h/%b/%b want %h/%b/%b", k, got_q[k].d, got_q[k].s, got_q[k].l, exp_q[k].d, exp_q[k].s, exp_q[k].l);
      end
    end
  endtask

  task automatic test_ratio1();
    int guard = 0;
    got1_q.delete(); exp1_q.delete();
    got1_strb_ok = 1'b1;
    while (exp1_q.size() < 500 && guard < 5000) begin
      step1($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      guard++;
    end
    repeat (3) step1(0, 8'h00, 0, 1);
    n_cmp++; if (exp1_q.size() != 500 || got1_q.size() != 500) begin
      n_bad++; $display("FAIL r1_count: got %0d beats want 500 (sent %0d)", got1_q.size(), exp1_q.size());
    end
    n_cmp++; if (!got1_strb_ok) begin n_bad++; $display("FAIL r1_strb: got a strobe other than 1 want 1"); end
    for (int k = 0; k < got1_q.size() && k < exp1_q.size(); k++) begin
      n_cmp++;
      if (got1_q[k].d !== exp1_q[k].d || got1_q[k].l !== exp1_q[k].l) begin
        n_bad++; $display("FAIL r1_beat%0d: got %h/%b want %h/%b", k, got1_q[k].d, got1_q[k].l, exp1_q[k].d, exp1_q[k].l);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst_req = 1'b0;
    a_in_data = '0; a_in_last = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_last = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    test_reset();
    test_full_word();
    test_short_word();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_ratio1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
